// File: rtl/seg7_display_ctrl_pkg.sv
// Shared definitions for the memory-mapped 8-digit seven-segment controller:
// register map codes, control bits, segment table and converter states.
package seg7_display_ctrl_pkg;

  typedef enum logic [1:0] {
    ADDR_VAL_LO = 2'b00,
    ADDR_VAL_HI = 2'b01,
    ADDR_CTRL   = 2'b10,
    ADDR_NONE   = 2'b11
  } seg_addr_e;

  localparam int CTRL_DEC    = 0;
  localparam int CTRL_ZBLANK = 1;
  localparam int CTRL_ENABLE = 2;

  typedef struct packed {
    logic enable;
    logic zblank;
    logic dec;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{enable: 1'b1, zblank: 1'b0, dec: 1'b0};

  // Segment g only, already placed in led[7:1] form.
  localparam logic [7:0] SEG_DASH = 8'h02;

  localparam int BCD_SHIFTS = 32;

  typedef enum logic [1:0] {
    BCD_IDLE  = 2'b00,
    BCD_SHIFT = 2'b01,
    BCD_DONE  = 2'b10
  } bcd_state_e;

  // Returns {a,b,c,d,e,f,g,dp} with dp forced low.
  function automatic logic [7:0] seg_encode(input logic [3:0] digit);
    logic [6:0] abcdefg;
    case (digit)
      4'h0: abcdefg = 7'h7E;
      4'h1: abcdefg = 7'h30;
      4'h2: abcdefg = 7'h6D;
      4'h3: abcdefg = 7'h79;
      4'h4: abcdefg = 7'h33;
      4'h5: abcdefg = 7'h5B;
      4'h6: abcdefg = 7'h5F;
      4'h7: abcdefg = 7'h70;
      4'h8: abcdefg = 7'h7F;
      4'h9: abcdefg = 7'h7B;
      4'hA: abcdefg = 7'h77;
      4'hB: abcdefg = 7'h1F;
      4'hC: abcdefg = 7'h4E;
      4'hD: abcdefg = 7'h3D;
      4'hE: abcdefg = 7'h4F;
      default: abcdefg = 7'h47;
    endcase
    return {abcdefg, 1'b0};
  endfunction

endpackage

// File: rtl/seg7_display_ctrl_bin2bcd_seq.sv
// Iterative double-dabble converter: 32-bit binary to 10 BCD digits in
// 32 shift cycles plus one DONE cycle; start restarts, abort returns to idle.
module seg7_display_ctrl_bin2bcd_seq
  import seg7_display_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] bin,
  output logic [39:0] bcd,
  output logic        busy,
  output logic        done
);

  bcd_state_e  state_q, state_d;
  logic [31:0] bin_q, bin_d;
  logic [39:0] bcd_q, bcd_d, bcd_adj;
  logic [4:0]  cnt_q, cnt_d;

  // Add-3 correction on every BCD digit that is 5 or more, ahead of the shift.
  for (genvar gi = 0; gi < 10; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                           : bcd_q[4*gi +: 4];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= BCD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = BCD_SHIFT;
    end else if (abort) begin
      state_d = BCD_IDLE;
    end else begin
      case (state_q)
        BCD_SHIFT: if (cnt_q == 5'(BCD_SHIFTS - 1)) state_d = BCD_DONE;
        BCD_DONE:  state_d = BCD_IDLE;
        default:   state_d = BCD_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == BCD_SHIFT) || (state_q == BCD_DONE);
    done = (state_q == BCD_DONE);
  end

  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (start) begin
      bin_d = bin;
      bcd_d = '0;
      cnt_d = '0;
    end else if (state_q == BCD_SHIFT && !abort) begin
      bin_d = bin_q << 1;
      bcd_d = (bcd_adj << 1) | {39'd0, bin_q[31]};
      cnt_d = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/seg7_display_ctrl.sv
// Memory-mapped 8-digit seven-segment controller: halfword value writes,
// hex or decimal display, zero blanking and a two-group multiplexed scan.
module seg7_display_ctrl
  import seg7_display_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        segwrite,
  input  logic        segcs,
  input  logic [1:0]  segaddr,
  input  logic [15:0] segwdata,
  output logic        busy,
  output logic [3:0]  ena_r,
  output logic [3:0]  ena_l,
  output logic [7:0]  led_r,
  output logic [7:0]  led_l
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  ctrl_t             ctrl_q, ctrl_d;
  logic [31:0]       value_q, value_d;
  logic [31:0]       shown_q, shown_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [3:0]        ena_r_q, ena_r_d, ena_l_q, ena_l_d;
  logic [7:0]        led_r_q, led_r_d, led_l_q, led_l_d;

  logic              wr_en;
  logic              conv_start, conv_abort, conv_busy, conv_done;
  logic [39:0]       conv_bcd;
  logic [7:0]        blank_vec;
  logic [3:0]        digit;
  logic [7:0]        seg;

  assign wr_en = segwrite && segcs && (seg_addr_e'(segaddr) != ADDR_NONE);

  always_comb begin
    value_d = value_q;
    ctrl_d  = ctrl_q;
    if (wr_en) begin
      case (seg_addr_e'(segaddr))
        ADDR_VAL_LO: value_d[15:0]  = segwdata;
        ADDR_VAL_HI: value_d[31:16] = segwdata;
        ADDR_CTRL:   ctrl_d = '{enable: segwdata[CTRL_ENABLE],
                                zblank: segwdata[CTRL_ZBLANK],
                                dec:    segwdata[CTRL_DEC]};
        default: ;
      endcase
    end
  end

  // Every accepted write in decimal mode (re)starts the converter from the new value.
  assign conv_start = wr_en && ctrl_d.dec;
  assign conv_abort = ctrl_q.dec && !ctrl_d.dec;

  seg7_display_ctrl_bin2bcd_seq u_bin2bcd (
    .clock (clock),
    .reset (reset),
    .start (conv_start),
    .abort (conv_abort),
    .bin   (value_d),
    .bcd   (conv_bcd),
    .busy  (conv_busy),
    .done  (conv_done)
  );

  // Shown digits are the display buffer; in decimal mode only a finished,
  // unsuperseded conversion may replace them.
  always_comb begin
    shown_d = shown_q;
    ovf_d   = ovf_q;
    if (!ctrl_d.dec) begin
      shown_d = value_d;
      ovf_d   = 1'b0;
    end else if (conv_done && !conv_start) begin
      shown_d = conv_bcd[31:0];
      ovf_d   = |conv_bcd[39:32];
    end
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_blank
    assign blank_vec[gi] = (gi != 0) && (shown_q[31:4*gi] == '0);
  end

  assign digit = shown_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    if (ovf_q) begin
      seg = SEG_DASH;
    end else if (ctrl_q.zblank && blank_vec[idx_q]) begin
      seg = 8'h00;
    end else begin
      seg = seg_encode(digit);
    end
    ena_r_d = '0;
    ena_l_d = '0;
    led_r_d = '0;
    led_l_d = '0;
    if (ctrl_q.enable) begin
      if (!idx_q[2]) begin
        ena_r_d = 4'b0001 << idx_q[1:0];
        led_r_d = seg;
      end else begin
        ena_l_d = 4'b0001 << idx_q[1:0];
        led_l_d = seg;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      ctrl_q  <= CTRL_RESET;
      shown_q <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      ena_r_q <= '0;
      ena_l_q <= '0;
      led_r_q <= '0;
      led_l_q <= '0;
    end else begin
      value_q <= value_d;
      ctrl_q  <= ctrl_d;
      shown_q <= shown_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ena_r_q <= ena_r_d;
      ena_l_q <= ena_l_d;
      led_r_q <= led_r_d;
      led_l_q <= led_l_d;
    end
  end

  assign busy  = conv_busy;
  assign ena_r = ena_r_q;
  assign ena_l = ena_l_q;
  assign led_r = led_r_q;
  assign led_l = led_l_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed bench for seg7_display_ctrl: a transaction-level display model
// checked every cycle, plus hand-computed segment/latency expectations.
module tb_seg7_display_ctrl;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        segwrite = 1'b0;
  logic        segcs = 1'b0;
  logic [1:0]  segaddr = 2'b00;
  logic [15:0] segwdata = 16'h0000;
  logic        busy;
  logic [3:0]  ena_r, ena_l;
  logic [7:0]  led_r, led_l;

  int n_vec = 0;
  int n_bad = 0;
  int busy_cnt = 0;
  bit tb_done = 0;

  seg7_display_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
    .clock    (clk),
    .reset    (rst),
    .segwrite (segwrite),
    .segcs    (segcs),
    .segaddr  (segaddr),
    .segwdata (segwdata),
    .busy     (busy),
    .ena_r    (ena_r),
    .ena_l    (ena_l),
    .led_r    (led_r),
    .led_l    (led_l)
  );

  always #5 clk = ~clk;

  // Model state: what the display shows, as decimal/hex digits.
  logic [6:0]  seg7 [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic [31:0] m_value = '0;
  logic [2:0]  m_ctrl = 3'b100;
  logic [3:0]  m_dig [8] = '{default: 4'h0};
  bit          m_ovf = 0;
  int          m_left = 0;
  int unsigned m_conv = 0;
  int          m_n = 0;
  int          mi;
  bit          m_wr;
  logic        exp_busy = 1'b0;
  logic [3:0]  exp_ena_r = '0, exp_ena_l = '0;
  logic [7:0]  exp_led_r = '0, exp_led_l = '0;

  function automatic logic [7:0] exp_seg(input int i);
    bit all_zero;
    if (m_ovf) return 8'h02;
    all_zero = 1;
    for (int k = i; k < 8; k++) if (m_dig[k] != 4'h0) all_zero = 0;
    if (m_ctrl[1] && i > 0 && all_zero) return 8'h00;
    return {seg7[m_dig[i]], 1'b0};
  endfunction

  task automatic load_dec(input int unsigned v);
    int unsigned t;
    t = v;
    m_ovf = (v > 32'd99_999_999);
    for (int k = 0; k < 8; k++) begin
      m_dig[k] = 4'(t % 10);
      t = t / 10;
    end
  endtask

  // Model: outputs after an edge reflect the state before it; conversions
  // occupy 33 busy cycles after the starting write.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_value = '0; m_ctrl = 3'b100; m_ovf = 0; m_left = 0; m_n = 0;
        for (int k = 0; k < 8; k++) m_dig[k] = 4'h0;
        exp_busy = 1'b0; exp_ena_r = '0; exp_ena_l = '0; exp_led_r = '0; exp_led_l = '0;
      end else begin
        mi = (m_n / SCAN_DIV) % 8;
        exp_ena_r = '0; exp_ena_l = '0; exp_led_r = '0; exp_led_l = '0;
        if (m_ctrl[2]) begin
          if (mi < 4) begin exp_ena_r = 4'(1 << mi);       exp_led_r = exp_seg(mi); end
          else        begin exp_ena_l = 4'(1 << (mi - 4)); exp_led_l = exp_seg(mi); end
        end
        m_n++;
        m_wr = segwrite && segcs && (segaddr != 2'b11);
        if (m_wr) begin
          case (segaddr)
            2'd0: m_value[15:0]  = segwdata;
            2'd1: m_value[31:16] = segwdata;
            default: m_ctrl = segwdata[2:0];
          endcase
        end
        if (m_wr && m_ctrl[0]) begin
          m_left = 33;
          m_conv = m_value;
        end else if (!m_ctrl[0]) begin
          m_left = 0;
        end else if (m_left > 0) begin
          m_left--;
          if (m_left == 0) load_dec(m_conv);
        end
        if (!m_ctrl[0]) begin
          m_ovf = 0;
          for (int k = 0; k < 8; k++) m_dig[k] = m_value[4*k +: 4];
        end
        exp_busy = (m_left > 0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!tb_done) begin
        n_vec++;
        if ({busy, ena_r, ena_l, led_r, led_l} !== {exp_busy, exp_ena_r, exp_ena_l, exp_led_r, exp_led_l}) begin
          n_bad++;
          $display("FAIL cycle_model t=%0t busy/ena_r/ena_l/led_r/led_l got %b/%b/%b/%h/%h expected %b/%b/%b/%h/%h",
                   $time, busy, ena_r, ena_l, led_r, led_l,
                   exp_busy, exp_ena_r, exp_ena_l, exp_led_r, exp_led_l);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic cs = 1'b1);
    segaddr = a; segwdata = d; segcs = cs; segwrite = 1'b1;
    @(negedge clk);
    segwrite = 1'b0; segcs = 1'b0;
  endtask

  task automatic chk_digit(input string name, input int d, input logic [7:0] exp);
    logic [3:0] oh;
    logic [7:0] seg;
    bit found;
    oh = 4'(1 << (d % 4));
    seg = 8'hxx;
    found = 0;
    for (int k = 0; k < 64 && !found; k++) begin
      @(negedge clk);
      if (d < 4 ? (ena_r == oh) : (ena_l == oh)) begin
        found = 1;
        seg = (d < 4) ? led_r : led_l;
      end
    end
    chk(name, {24'd0, seg}, {24'd0, exp});
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && busy; k++) @(negedge clk);
    chk("busy_falls", {31'd0, busy}, 32'd0);
  endtask

  int b0;

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ena", {24'd0, ena_r, ena_l}, 32'd0);
    chk("rst_led", {16'd0, led_r, led_l}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_digit_ena", {28'd0, ena_r}, 32'h1);
    chk("first_digit_led", {24'd0, led_r}, 32'hFC);
    for (int d = 0; d < 8; d++) chk_digit($sformatf("scan_zero_d%0d", d), d, 8'hFC);

    // Ignored writes, then hex value ABCD1234.
    wr(2'b00, 16'hFFFF, 1'b0);
    wr(2'b11, 16'h0007);
    wr(2'b00, 16'h1234);
    wr(2'b01, 16'hABCD);
    chk_digit("hex_d7_A", 7, 8'hEE);
    chk_digit("hex_d4_d", 4, 8'h7A);
    chk_digit("hex_d0_4", 0, 8'h66);
    chk_digit("hex_d3_1", 3, 8'h60);

    // Decimal 12345 with zero blanking.
    wr(2'b01, 16'h0000);
    wr(2'b00, 16'h3039);
    b0 = busy_cnt;
    wr(2'b10, 16'h0007);
    wait_idle();
    chk("busy_12345", busy_cnt - b0, 32'd33);
    chk_digit("dec_d0_5", 0, 8'hB6);
    chk_digit("dec_d2_3", 2, 8'hF2);
    chk_digit("dec_d4_1", 4, 8'h60);
    chk_digit("dec_d5_blank", 5, 8'h00);
    chk_digit("dec_d7_blank", 7, 8'h00);

    // 100_000_000 overflows the eight digits.
    wr(2'b01, 16'h05F5);
    wr(2'b00, 16'hE100);
    wait_idle();
    chk_digit("ovf_d0_dash", 0, 8'h02);
    chk_digit("ovf_d7_dash", 7, 8'h02);

    // Restart mid-conversion: 9 superseded by 0x42 after ten busy cycles.
    wr(2'b10, 16'h0003);
    wr(2'b01, 16'h0000);
    wr(2'b00, 16'h0009);
    b0 = busy_cnt;
    wr(2'b10, 16'h0007);
    repeat (9) @(negedge clk);
    wr(2'b00, 16'h0042);
    wait_idle();
    chk("busy_restart", busy_cnt - b0, 32'd43);
    chk_digit("restart_d0_6", 0, 8'hBE);
    chk_digit("restart_d1_6", 1, 8'hBE);
    chk_digit("restart_d2_blank", 2, 8'h00);

    // Dec -> hex aborts; busy must be low right after the write edge.
    wr(2'b10, 16'h0007);
    repeat (3) @(negedge clk);
    wr(2'b10, 16'h0006);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk_digit("abort_hex_d0_2", 0, 8'hDA);

    // Asynchronous reset in SHIFT and mid-scan.
    wr(2'b10, 16'h0007);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_ena", {24'd0, ena_r, ena_l}, 32'd0);
    chk("async_rst_led", {16'd0, led_r, led_l}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ena", {28'd0, ena_r}, 32'h1);
    chk_digit("post_rst_d7_unblanked", 7, 8'hFC);

    tb_done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
